ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch front-end for the 5-stage pipelined MIPS.
- Owns the PC and issues sequential requests to an instruction memory whose latency is variable but whose responses return in order.
- Buffers the returned words in a small prefetch queue and presents instruction/PC+4 pairs to the IF/ID register.
- Accepts redirects (taken branch or jump, from MEM) and stalls (load-use hazard, from decode).

Parameters:
- DEPTH, 4, queue entries; also the maximum number of outstanding requests. Must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- d_ready  in  1  decode can accept this cycle; driven low on a hazard stall.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, in order.
- imem_rdata  in  32  instruction word.
- d_valid  out  1  head entry valid toward IF/ID.
- d_inst  out  32  head instruction; 32'h0 (NOP) when d_valid=0.
- d_pc  out  32  head PC+4; 0 when d_valid=0.
- err_rsp  out  1  sticky flag: imem_rvalid arrived with no request outstanding.

Behaviour:
- Reset while rst=1, applied immediately:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - occupancy, pend and disc counters are 0.
  - imem_req=0, d_valid=0, d_inst=0, d_pc=0, err_rsp=0.
  - Reset mid-operation abandons all in-flight responses. Responses arriving after reset deassertion with no outstanding request set err_rsp.
- Credit rule: imem_req = (occ + pend + disc < DEPTH) and not redirect_valid.
  - imem_addr = fetch_pc.
  - Counter width is $clog2(DEPTH)+1.
- Grant (imem_req and imem_gnt): fetch_pc += 4 (wraps mod 2^32); pend += 1.
- Ungranted request:
  - imem_addr and imem_req hold stable until gnt.
  - Only a redirect may abandon it. The redirect cycle forces imem_req=0, and the next cycle presents redirect_pc.
- Response with disc>0: the word is dropped and disc -= 1.
- Response with disc=0 and pend>0:
  - Push {imem_rdata, rsp_pc+4}; rsp_pc += 4; pend -= 1.
  - The credit rule guarantees the queue is never full at a push.
- Pop: d_valid and d_ready.
  - d_valid = occ != 0 and not redirect_valid.
  - d_inst and d_pc come from the head entry.
  - Push and pop in the same cycle leave occ unchanged.
- Latency:
  - Grant in cycle N, rvalid in N+1 at the earliest.
  - Entry visible with d_valid=1 in N+2; there is no response-to-output bypass.
- Redirect cycle, with priority over all other events:
  - occ := 0 (queue flushed, no pop).
  - disc := disc + pend + (1 if an accepted-grant happens this cycle, else 0) − (1 if a response is discarded this cycle, else 0); pend := 0.
    - A response arriving in the redirect cycle is discarded. It counts against the old pend/disc.
    - Because imem_req=0 in the redirect cycle, the grant term is 0.
  - fetch_pc := rsp_pc := {redirect_pc[31:2], 2'b00}.
- Redirect while empty and idle: behaves the same (fetch restarts, nothing to discard).
- Back-to-back redirects: the last one wins, and discard accounting accumulates.
- Stall: d_ready=0 holds the head; fetching continues until credits are exhausted.
- States, implied by the counters:
  - RUN: credits available.
  - FULL: occ+pend+disc = DEPTH, imem_req=0.
  - DRAIN: disc>0, requests still allowed if credits permit.

Decomposition:
- Shared mips_pkg:
  - XLEN=32.
  - NOP_INST=32'h0000_0000.
  - DEFAULT_RESET_PC.
  - Typedef ifq_entry_t {inst[31:0], pc4[31:0]}.
- Sub-module ifq_fifo (DEPTH, entry type):
  - Storage, head/tail pointers, occ counter.
  - Synchronous flush and async reset.
  - Outputs empty/count.
- The credit/discard/PC logic stays in ifetch_queue.

Test Plan:
1. Release rst with imem gnt=1 and fixed 1-cycle rvalid latency; mem[i]=32'h1000_0000+i; d_ready=1. Expected: imem_addr=0,4,8,…; first d_valid two cycles after the first grant; d_pc=4,8,12; d_inst=32'h1000_0000,…_0001,…_0002 with no bubbles.
2. Hold d_ready=0. Expected: exactly 4 grants then imem_req=0 and occ=4. Raise d_ready: 4 pops with d_pc=4..16, and fetch resumes at addr 16.
3. Use 3-cycle response latency and assert redirect_pc=32'h40 with 2 requests pending. Expected: the next 2 rvalids are dropped; the first d_valid after that has d_pc=32'h44 and d_inst=mem[16]; err_rsp stays 0.
4. Assert redirect_pc=32'h80 in the same cycle as an rvalid and a d_ready pop. Expected: the pop does not occur (d_valid=0 that cycle); the response is dropped; the queue is empty the next cycle; the next d_pc=32'h84.
5. Hold imem_gnt=0 for 3 cycles. Expected: imem_req=1 and imem_addr constant throughout; then a redirect makes imem_req=0 for one cycle, after which imem_addr=redirect_pc.
6. Assert rst mid-stream with occ=3. Expected: d_valid, d_inst, d_pc and imem_req go to 0 before the next clock edge; after release, fetch restarts at RESET_PC. Then inject a stray rvalid: err_rsp=1 and stays high.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: word size, NOP encoding, default reset
// PC and the prefetch queue entry layout.
package mips_pkg;

    localparam int unsigned      XLEN             = 32;
    localparam logic [XLEN-1:0]  NOP_INST         = 32'h0000_0000;
    localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0]  INST_BYTES       = 32'd4;
    localparam logic [XLEN-1:0]  WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    // One fetched instruction together with the PC+4 value handed to IF/ID.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } ifq_entry_t;

    // Fetch status, derived purely from the occupancy/pending/discard counters.
    typedef enum logic [1:0] {
        IFQ_RUN,
        IFQ_FULL,
        IFQ_DRAIN
    } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue storage: circular buffer with head/tail pointers and an
// occupancy counter. Flush is synchronous and overrides push/pop.
module ifq_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = ifq_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    entry_t mem [DEPTH];
    ptr_t   rd_ptr;
    ptr_t   wr_ptr;
    cnt_t   occ;
    logic   do_push;
    logic   do_pop;

    // Qualify push/pop so the queue can never over- or underflow.
    always_comb begin
        do_pop  = pop && (occ != '0);
        do_push = push && ((occ != cnt_t'(DEPTH)) || do_pop);
    end

    // Entry storage; contents are only ever read once counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue without a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + cnt_t'(1);
                2'b01:   occ <= occ - cnt_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head entry and status toward the fetch control.
    always_comb begin
        head  = mem[rd_ptr];
        empty = (occ == '0);
        count = occ;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the PC, issues in-order requests to a
// variable-latency instruction memory under a credit limit, buffers returned
// words and presents instruction / PC+4 pairs to IF/ID. Redirects flush the
// queue and turn all outstanding requests into responses to discard.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            d_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            d_valid,
    output logic [XLEN-1:0] d_inst,
    output logic [XLEN-1:0] d_pc,
    output logic            err_rsp
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [SW-1:0] sum_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_base;
    cnt_t            occ;
    cnt_t            pend;
    cnt_t            disc;
    sum_t            credit_used;
    ifq_state_t      fetch_state;
    logic            grant;
    logic            rsp_drop;
    logic            rsp_take;
    logic            rsp_stray;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    ifq_entry_t      push_entry;
    ifq_entry_t      head_entry;

    // Fetch status from the credits consumed by queued, pending and discarded words.
    always_comb begin
        credit_used = sum_t'(occ) + sum_t'(pend) + sum_t'(disc);
        if (credit_used >= sum_t'(DEPTH)) begin
            fetch_state = IFQ_FULL;
        end else if (disc != '0) begin
            fetch_state = IFQ_DRAIN;
        end else begin
            fetch_state = IFQ_RUN;
        end
    end

    // Memory handshake decode and response classification.
    always_comb begin
        imem_req      = !rst && (fetch_state != IFQ_FULL) && !redirect_valid;
        imem_addr     = fetch_pc;
        grant         = imem_req && imem_gnt;
        rsp_drop      = imem_rvalid && (disc != '0);
        rsp_take      = imem_rvalid && (disc == '0) && (pend != '0);
        rsp_stray     = imem_rvalid && (disc == '0) && (pend == '0);
        push          = rsp_take && !redirect_valid;
        redirect_base = redirect_pc & WORD_ALIGN_MASK;
        push_entry    = '{inst: imem_rdata, pc4: rsp_pc + INST_BYTES};
    end

    // Decode-side presentation; the head is hidden during a redirect.
    always_comb begin
        d_valid = !fifo_empty && !redirect_valid;
        pop     = d_valid && d_ready;
        d_inst  = d_valid ? head_entry.inst : NOP_INST;
        d_pc    = d_valid ? head_entry.pc4  : '0;
    end

    // PCs, pending/discard accounting and the sticky stray-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            pend     <= '0;
            disc     <= '0;
            err_rsp  <= 1'b0;
        end else begin
            if (rsp_stray) begin
                err_rsp <= 1'b1;
            end
            if (redirect_valid) begin
                // Every pending request becomes a discard; a response landing
                // now retires one of them. No grant term: imem_req is low here.
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                pend     <= '0;
                disc     <= disc + pend - cnt_t'(rsp_drop || rsp_take);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + INST_BYTES;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + INST_BYTES;
                end
                pend <= pend + cnt_t'(grant) - cnt_t'(rsp_take);
                disc <= disc - cnt_t'(rsp_drop);
            end
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ifq_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (occ)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: an in-order memory responder with random latency,
// and a reference model tracking the instruction stream per fetch epoch.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        d_valid;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic        err_rsp;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_ready        (d_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .d_valid        (d_valid),
        .d_inst         (d_inst),
        .d_pc           (d_pc),
        .err_rsp        (err_rsp)
    );

    always #5 clk = ~clk;

    // One request in flight at the memory, tagged with the fetch epoch it belongs to.
    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    req_t        rq[$];
    int unsigned cyc;
    int unsigned epoch;
    int unsigned buffered;
    int unsigned pops;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic        exp_err;
    int          checks;
    int          errors;
    int unsigned gnt_pct;
    int unsigned rdy_pct;
    int unsigned lat_lo;
    int unsigned lat_hi;
    logic        stray_inject;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic redir, input logic [31:0] target);
        int unsigned old_n;
        int unsigned cur_n;
        int unsigned lat;
        logic        rsp;
        logic        exp_req;
        logic        exp_dv;
        logic        g;
        logic        p;
        req_t        r;
        redirect_valid = redir;
        redirect_pc    = target;
        imem_gnt       = ($urandom_range(99) < gnt_pct);
        d_ready        = ($urandom_range(99) < rdy_pct);
        rsp            = (rq.size() != 0) && (rq[0].due <= cyc);
        imem_rvalid    = rsp || stray_inject;
        imem_rdata     = rsp ? mem_word(rq[0].addr) : 32'hDEAD_BEEF;
        #1;
        old_n = 0;
        cur_n = 0;
        foreach (rq[i]) begin
            if (rq[i].epoch == epoch) cur_n++;
            else old_n++;
        end
        exp_req = ((old_n + cur_n + buffered) < DEPTH) && !redir;
        exp_dv  = (buffered != 0) && !redir;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        chk("d_valid", 32'(d_valid), 32'(exp_dv));
        if (exp_dv) begin
            chk("d_pc", d_pc, exp_pc + 32'd4);
            chk("d_inst", d_inst, mem_word(exp_pc));
        end else begin
            chk("d_pc_idle", d_pc, 32'h0);
            chk("d_inst_idle", d_inst, 32'h0);
        end
        chk("err_rsp", 32'(err_rsp), 32'(exp_err));
        g = exp_req && imem_gnt;
        p = exp_dv && d_ready;
        @(posedge clk);
        if (rsp) begin
            r = rq.pop_front();
            if (r.epoch == epoch && !redir) buffered++;
        end else if (imem_rvalid) begin
            exp_err = 1'b1;
        end
        if (p) begin
            buffered--;
            pops++;
            exp_pc = exp_pc + 32'd4;
        end
        if (g) begin
            lat = $urandom_range(lat_hi, lat_lo);
            rq.push_back('{addr: exp_fetch, epoch: epoch, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            epoch++;
            buffered  = 0;
            exp_fetch = target & 32'hFFFF_FFFC;
            exp_pc    = target & 32'hFFFF_FFFC;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset asynchronously, check outputs clear before any edge, then release.
    task automatic apply_reset();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        rst            = 1'b1;
        #1;
        chk("rst_d_valid", 32'(d_valid), 32'h0);
        chk("rst_d_inst", d_inst, 32'h0);
        chk("rst_d_pc", d_pc, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_err_rsp", 32'(err_rsp), 32'h0);
        rq.delete();
        epoch++;
        buffered  = 0;
        exp_fetch = RESET_PC;
        exp_pc    = RESET_PC;
        exp_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        epoch          = 0;
        buffered       = 0;
        pops           = 0;
        stray_inject   = 1'b0;
        redirect_pc    = 32'h0;
        d_ready        = 1'b0;
        imem_rdata     = 32'h0;
        gnt_pct        = 100;
        rdy_pct        = 100;
        lat_lo         = 1;
        lat_hi         = 1;
        apply_reset();

        // Streaming with 1-cycle latency: grant every cycle, pops from cycle 2 on.
        repeat (12) step(1'b0, 32'h0);
        chk("stream_pops", pops, 32'd10);

        // Decode stall: fetch runs until credits are exhausted, then resumes.
        rdy_pct = 0;
        repeat (10) step(1'b0, 32'h0);
        rdy_pct = 100;
        repeat (8) step(1'b0, 32'h0);

        // Long latency redirect with requests pending.
        lat_lo = 3;
        lat_hi = 3;
        repeat (6) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0040);
        repeat (14) step(1'b0, 32'h0);

        // Redirect coinciding with a response and a pop.
        lat_lo = 1;
        lat_hi = 1;
        repeat (6) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0080);
        repeat (6) step(1'b0, 32'h0);

        // Ungranted request held, then abandoned by a redirect (unaligned target).
        gnt_pct = 0;
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0103);
        gnt_pct = 100;
        repeat (6) step(1'b0, 32'h0);

        // Reset with three entries queued, restart, then a stray response.
        rdy_pct = 0;
        for (int i = 0; i < 20 && buffered < 3; i++) step(1'b0, 32'h0);
        apply_reset();
        gnt_pct = 0;
        rdy_pct = 100;
        step(1'b0, 32'h0);
        stray_inject = 1'b1;
        step(1'b0, 32'h0);
        stray_inject = 1'b0;
        gnt_pct = 100;
        repeat (6) step(1'b0, 32'h0);

        // Random traffic: grants, stalls, latencies and redirects.
        gnt_pct = 70;
        rdy_pct = 70;
        lat_lo  = 1;
        lat_hi  = 4;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(99) < 6) step(1'b1, $urandom);
            else step(1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
